lsu_ctrl: RTL and testbench

Multi-cycle load/store controller that sits between the single-cycle core's execute stage and a handshaked data-memory bus. It accepts one memory operation described by the decoder's control fields (`mem_wr`, `rd_wr_mem` funct3, computed address, store data). It then runs the bus transaction: request/grant, then read-data wait. It stalls the core until the operation completes and returns a lane-extracted, sign- or zero-extended load result, or a fault. It handles byte-lane steering for stores, checks alignment and funct3 legality, and enforces a bus timeout.

---
 rtl/lsu_ctrl.sv | 175 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store controller between the execute stage and a handshaked data bus.
// Runs one request/grant (and read-wait) transaction per accepted memory op.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_fault,
  output logic [31:0] o_rdata_out,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

  state_t      r_state;
  logic        r_is_load;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_cnt;
  logic        r_done;
  logic        r_fault;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_legal;
  logic        w_tmo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  function automatic logic is_legal(input logic ld, input logic st,
                                    input logic [2:0] f3, input logic [1:0] off);
    logic f3_ok;
    logic align_ok;
    f3_ok = ld ? (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
               : (f3 inside {3'b000, 3'b001, 3'b010});
    case (f3[1:0])
      2'b01:   align_ok = ~off[0];
      2'b10:   align_ok = (off == 2'b00);
      default: align_ok = 1'b1;
    endcase
    return (ld ^ st) & f3_ok & align_ok;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] rdata,
                                         input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] lane;
    lane = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{lane[7]}}, lane[7:0]};
      3'b100:  return {24'd0, lane[7:0]};
      3'b001:  return {{16{lane[15]}}, lane[15:0]};
      3'b101:  return {16'd0, lane[15:0]};
      default: return lane;
    endcase
  endfunction

  assign w_accept = (r_state == S_IDLE) && i_start && (i_is_load || i_is_store);
  assign w_legal  = is_legal(i_is_load, i_is_store, i_funct3, i_addr[1:0]);
  assign w_tmo    = (TIMEOUT_CYCLES != 0) && (r_cnt == TIMEOUT_CYCLES);

  // Store lane steering is resolved at accept so the bus sees only registered values.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_wdata;
    if (i_is_store && !i_is_load) begin
      case (i_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << i_addr[1:0];
          w_wdata = {4{i_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{i_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_is_load <= 1'b0;
      r_funct3  <= 3'd0;
      r_addr    <= 32'd0;
      r_be      <= 4'd0;
      r_wdata   <= 32'd0;
      r_cnt     <= 32'd0;
      r_done    <= 1'b0;
      r_fault   <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_load <= i_is_load;
            r_funct3  <= i_funct3;
            r_addr    <= i_addr;
            r_be      <= w_be;
            r_wdata   <= w_wdata;
            r_cnt     <= 32'd0;
            if (w_legal) begin
              r_state <= S_REQ;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_fault <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (i_bus_gnt) begin
            r_cnt <= 32'd0;
            if (r_is_load) begin
              r_state <= S_WAIT_R;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else if (w_tmo) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_fault <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_WAIT_R: begin
          if (i_bus_rvalid) begin
            r_rdata <= extend(i_bus_rdata, r_addr[1:0], r_funct3);
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (w_tmo) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_fault <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_stall     = w_accept || (r_state == S_REQ) || (r_state == S_WAIT_R);
  assign o_done      = r_done;
  assign o_fault     = r_fault;
  assign o_rdata_out = r_rdata;
  assign o_bus_req   = (r_state == S_REQ);
  assign o_bus_we    = (r_state == S_REQ) && !r_is_load;
  assign o_bus_addr  = {r_addr[31:2], 2'b00};
  assign o_bus_be    = r_be;
  assign o_bus_wdata = r_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: every completed operation is matched against a
// scoreboard entry queued when the operation was driven.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, isLoad, isStore;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, fault;
  logic [31:0] rdataOut;
  logic        busReq, busWe;
  logic [31:0] busAddr;
  logic [3:0]  busBe;
  logic [31:0] busWdata;
  logic        busGnt, busRvalid;
  logic [31:0] busRdata;

  typedef struct {
    logic        fault;
    logic        isLoad;
    logic [31:0] data;
  } expItem_t;

  expItem_t expQ[$];
  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_is_load(isLoad),
    .i_is_store(isStore), .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata),
    .o_stall(stall), .o_done(done), .o_fault(fault), .o_rdata_out(rdataOut),
    .o_bus_req(busReq), .o_bus_we(busWe), .o_bus_addr(busAddr), .o_bus_be(busBe),
    .o_bus_wdata(busWdata), .i_bus_gnt(busGnt), .i_bus_rvalid(busRvalid),
    .i_bus_rdata(busRdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic ld, input logic sw,
                               input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    start = st; isLoad = ld; isStore = sw; funct3 = f3; addr = a; wdata = wd;
    #1;
  endtask

  task automatic goIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
  endtask

  task automatic pushExp(input logic f, input logic l, input logic [31:0] d);
    expItem_t e;
    e.fault = f; e.isLoad = l; e.data = d;
    expQ.push_back(e);
  endtask

  task automatic checkDone(input string tag);
    expItem_t e;
    checkOutput({tag, ".done"}, 32'(done), 32'd1);
    if (expQ.size() == 0) begin
      nChecks++;
      nFail++;
      $error("[TB] FAIL %s.scoreboard: observed empty queue expected pending op", tag);
    end else begin
      e = expQ.pop_front();
      checkOutput({tag, ".fault"}, 32'(fault), 32'(e.fault));
      if (e.isLoad && !e.fault) checkOutput({tag, ".rdata"}, rdataOut, e.data);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 0; isLoad = 0; isStore = 0; funct3 = 0; addr = 0; wdata = 0;
    busGnt = 0; busRvalid = 0; busRdata = 0;
    #12;
    checkOutput("rst.stall", 32'(stall), 32'd0);
    checkOutput("rst.done", 32'(done), 32'd0);
    checkOutput("rst.fault", 32'(fault), 32'd0);
    checkOutput("rst.rdata", rdataOut, 32'd0);
    checkOutput("rst.req", 32'(busReq), 32'd0);
    checkOutput("rst.we", 32'(busWe), 32'd0);
    checkOutput("rst.addr", busAddr, 32'd0);
    checkOutput("rst.be", 32'(busBe), 32'd0);
    checkOutput("rst.wdata", busWdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // LB at 0x103, zero wait
    pushExp(1'b0, 1'b1, 32'hFFFF_FF80);
    busGnt = 1; busRvalid = 1; busRdata = 32'h80FF_1234;
    applyStimulus(1, 1, 0, 3'b000, 32'h103, 32'd0);
    checkOutput("lb.c0.stall", 32'(stall), 32'd1);
    checkOutput("lb.c0.req", 32'(busReq), 32'd0);
    tick();
    checkOutput("lb.c1.req", 32'(busReq), 32'd1);
    checkOutput("lb.c1.addr", busAddr, 32'h100);
    checkOutput("lb.c1.be", 32'(busBe), 32'hF);
    checkOutput("lb.c1.we", 32'(busWe), 32'd0);
    tick();
    checkOutput("lb.c2.req", 32'(busReq), 32'd0);
    checkOutput("lb.c2.stall", 32'(stall), 32'd1);
    checkOutput("lb.c2.done", 32'(done), 32'd0);
    tick();
    goIdle();
    checkDone("lb");
    checkOutput("lb.c3.stall", 32'(stall), 32'd0);
    tick();
    checkOutput("lb.c4.fault", 32'(fault), 32'd0);

    // LBU at 0x103
    pushExp(1'b0, 1'b1, 32'h0000_0080);
    applyStimulus(1, 1, 0, 3'b100, 32'h103, 32'd0);
    tick(); tick(); tick();
    goIdle();
    checkDone("lbu");
    tick();

    // SH at 0x202 with grant delayed three cycles
    pushExp(1'b0, 1'b0, 32'd0);
    busGnt = 0; busRvalid = 0;
    applyStimulus(1, 0, 1, 3'b001, 32'h202, 32'h1234_ABCD);
    checkOutput("sh.c0.stall", 32'(stall), 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      busGnt = (i == 3);
      checkOutput($sformatf("sh.req%0d", i), 32'(busReq), 32'd1);
      checkOutput($sformatf("sh.be%0d", i), 32'(busBe), 32'hC);
      checkOutput($sformatf("sh.wdata%0d", i), busWdata, 32'hABCD_ABCD);
      checkOutput($sformatf("sh.we%0d", i), 32'(busWe), 32'd1);
      checkOutput($sformatf("sh.stall%0d", i), 32'(stall), 32'd1);
      tick();
    end
    busGnt = 0;
    goIdle();
    checkDone("sh");
    checkOutput("sh.done.req", 32'(busReq), 32'd0);
    tick();
    checkOutput("sh.idle.stall", 32'(stall), 32'd0);

    // SB at 0x003
    pushExp(1'b0, 1'b0, 32'd0);
    busGnt = 1;
    applyStimulus(1, 0, 1, 3'b000, 32'h003, 32'h0000_00A5);
    tick();
    checkOutput("sb.be", 32'(busBe), 32'h8);
    checkOutput("sb.wdata", busWdata, 32'hA5A5_A5A5);
    tick();
    goIdle();
    checkDone("sb");
    busGnt = 0;
    tick();

    // Misaligned LW and illegal-funct3 store fault without bus traffic
    pushExp(1'b1, 1'b1, 32'd0);
    applyStimulus(1, 1, 0, 3'b010, 32'h101, 32'd0);
    tick();
    checkDone("lw_mis");
    checkOutput("lw_mis.req", 32'(busReq), 32'd0);
    goIdle();
    tick();
    pushExp(1'b1, 1'b0, 32'd0);
    applyStimulus(1, 0, 1, 3'b100, 32'h100, 32'h5555_5555);
    tick();
    checkDone("sw_ill");
    checkOutput("sw_ill.req", 32'(busReq), 32'd0);
    goIdle();
    tick();

    // Spurious rvalid in IDLE is ignored
    busRvalid = 1; busRdata = 32'hFFFF_FFFF;
    tick(); tick();
    checkOutput("spur.idle.stall", 32'(stall), 32'd0);
    checkOutput("spur.idle.done", 32'(done), 32'd0);
    checkOutput("spur.idle.rdata", rdataOut, 32'h0000_0080);

    // Timeout in REQ with rvalid still asserted
    pushExp(1'b1, 1'b1, 32'd0);
    applyStimulus(1, 1, 0, 3'b010, 32'h300, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("tmo.req%0d", i), 32'(busReq), 32'd1);
      tick();
    end
    goIdle();
    busRvalid = 0;
    checkDone("tmo");
    checkOutput("tmo.reqdrop", 32'(busReq), 32'd0);
    checkOutput("tmo.rdata", rdataOut, 32'h0000_0080);
    tick();
    checkOutput("tmo.idle.fault", 32'(fault), 32'd0);
    checkOutput("tmo.idle.stall", 32'(stall), 32'd0);

    // Grant on exactly the limit cycle wins
    pushExp(1'b0, 1'b0, 32'd0);
    applyStimulus(1, 0, 1, 3'b010, 32'h304, 32'hCAFE_F00D);
    tick();
    for (int i = 0; i < 5; i++) begin
      busGnt = (i == 4);
      checkOutput($sformatf("lim.req%0d", i), 32'(busReq), 32'd1);
      tick();
    end
    busGnt = 0;
    goIdle();
    checkDone("lim");
    tick();

    // Back-to-back LW then SW with start held high
    pushExp(1'b0, 1'b1, 32'hDEAD_BEEF);
    busGnt = 1; busRvalid = 1; busRdata = 32'hDEAD_BEEF;
    applyStimulus(1, 1, 0, 3'b010, 32'h400, 32'd0);
    tick(); tick(); tick();
    pushExp(1'b0, 1'b0, 32'd0);
    applyStimulus(1, 0, 1, 3'b010, 32'h404, 32'h1122_3344);
    checkDone("b2b.lw");
    checkOutput("b2b.done.stall", 32'(stall), 32'd0);
    tick();
    checkOutput("b2b.acc.stall", 32'(stall), 32'd1);
    checkOutput("b2b.acc.req", 32'(busReq), 32'd0);
    tick();
    checkOutput("b2b.sw.we", 32'(busWe), 32'd1);
    checkOutput("b2b.sw.addr", busAddr, 32'h404);
    checkOutput("b2b.sw.wdata", busWdata, 32'h1122_3344);
    tick();
    goIdle();
    busGnt = 0; busRvalid = 0;
    checkDone("b2b.sw");
    tick();

    // Reset during WAIT_R abandons the load
    pushExp(1'b0, 1'b1, 32'd0);
    busGnt = 1; busRvalid = 0;
    applyStimulus(1, 1, 0, 3'b001, 32'h502, 32'd0);
    tick(); tick();
    checkOutput("rstw.wait.stall", 32'(stall), 32'd1);
    #1;
    rst = 1'b1;
    start = 0; isLoad = 0;
    #1;
    checkOutput("rstw.req", 32'(busReq), 32'd0);
    checkOutput("rstw.stall", 32'(stall), 32'd0);
    checkOutput("rstw.rdata", rdataOut, 32'd0);
    checkOutput("rstw.addr", busAddr, 32'd0);
    checkOutput("rstw.be", 32'(busBe), 32'd0);
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("rstw.nodone", 32'(done), 32'd0);

    pushExp(1'b0, 1'b1, 32'hFFFF_8001);
    busGnt = 1; busRvalid = 1; busRdata = 32'h8001_7FFF;
    applyStimulus(1, 1, 0, 3'b001, 32'h502, 32'd0);
    tick(); tick(); tick();
    goIdle();
    checkDone("lh_after_rst");
    busGnt = 0; busRvalid = 0;
    tick();
    checkOutput("sb.empty", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
